// File: rtl/fc_pkg.sv
// fc_pkg: values and types shared by the FC input collector slice.
//   FC_INPUT_SIZE     : words per frame (120)
//   WORD_SIZE         : bits per signed fixed-point feature word (16)
//   COUNT_WIDTH       : word-index counter width (2^7 >= 120)
//   word_t            : one feature word
//   collector_state_t : COLLECT (filling the vector) / HOLD (vector frozen for FC)
package fc_pkg;

  localparam int FC_INPUT_SIZE = 120;
  localparam int WORD_SIZE     = 16;
  localparam int COUNT_WIDTH   = 7;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } collector_state_t;

endpackage

// File: rtl/fc_input_collector_if.sv
// fc_input_collector_if: valid/ready word stream from the CNN into the collector.
//   in_valid : word present on in_data (master -> slave)
//   in_data  : CNN feature word        (master -> slave)
//   in_last  : final word of a CNN frame, qualified by in_valid (master -> slave)
//   in_ready : collector accepts a word this cycle (slave -> master)
// Modports: master (CNN side / testbench driver), slave (collector).
interface fc_input_collector_if
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_SIZE
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/fc_input_collector_rise_detect.sv
// rise_detect: rising-edge detector for the FC stage's done level.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears done_q
//   level_i: FC_done level
//   rise_o : level_i high while its registered copy done_q is still low
// done_q is updated every cycle regardless of what the collector is doing, so
// a done level that stays high never produces a second rise.
module rise_detect
  import fc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic done_q;

  // Registered copy of the done level.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= level_i;
    end
  end

  assign rise_o = level_i & ~done_q;

endmodule

// File: rtl/fc_input_collector.sv
// fc_input_collector: gathers FC_INPUT_SIZE CNN words from a valid/ready stream
// into a parallel vector for the FC stage.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset, highest priority
//   stream      : fc_input_collector_if.slave (in_valid/in_data/in_last/in_ready)
//   FC_done     : FC stage done level; only its rising edge releases HOLD
//   FC_inputs   : registered frame vector, word 0 = first word accepted
//   CNN_ready   : frame complete and held for the FC stage
//   frame_error : one-cycle pulse after a short frame is discarded
// Optional feature: define FC_COLLECTOR_RELU_EN to store negative words as 0
// (ReLU on ingest). Handshake and timing are identical either way.
module fc_input_collector
  import fc_pkg::*;
(
  input  logic                                        clk,
  input  logic                                        rst,
  fc_input_collector_if.slave                         stream,
  input  logic                                        FC_done,
  output logic [0:FC_INPUT_SIZE-1][WORD_SIZE-1:0]     FC_inputs,
  output logic                                        CNN_ready,
  output logic                                        frame_error
);

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(FC_INPUT_SIZE - 1);

  collector_state_t                          state_q;
  logic [COUNT_WIDTH-1:0]                    count_q;
  logic [0:FC_INPUT_SIZE-1][WORD_SIZE-1:0]   frame_q;
  logic                                      in_ready_q;
  logic                                      cnn_ready_q;
  logic                                      frame_error_q;

  logic  done_rise;
  logic  beat;
  word_t store_d;

  rise_detect u_rise_detect (
    .clk    (clk),
    .rst    (rst),
    .level_i(FC_done),
    .rise_o (done_rise)
  );

  // in_ready_q is only ever high in COLLECT, so it doubles as the state qualifier.
  assign beat = stream.in_valid & in_ready_q;

  // Word actually written into the vector; optionally clamps negatives to zero.
  always_comb begin
    store_d = stream.in_data;
`ifdef FC_COLLECTOR_RELU_EN
    if (stream.in_data[WORD_SIZE-1]) begin
      store_d = '0;
    end
`endif
  end

  // Collector FSM. in_ready/CNN_ready are registered alongside the state so
  // they always match it and never depend combinationally on the inputs.
  // The final index completes the frame even without in_last; in_last on an
  // earlier beat discards the frame without storing that word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= COLLECT;
      count_q       <= '0;
      frame_q       <= '0;
      in_ready_q    <= 1'b1;
      cnn_ready_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (beat) begin
            if (count_q == LAST_IDX) begin
              frame_q[count_q] <= store_d;
              count_q          <= '0;
              state_q          <= HOLD;
              in_ready_q       <= 1'b0;
              cnn_ready_q      <= 1'b1;
            end else if (stream.in_last) begin
              count_q       <= '0;
              frame_error_q <= 1'b1;
            end else begin
              frame_q[count_q] <= store_d;
              count_q          <= count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (done_rise) begin
            state_q     <= COLLECT;
            in_ready_q  <= 1'b1;
            cnn_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= COLLECT;
          in_ready_q  <= 1'b1;
          cnn_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign stream.in_ready = in_ready_q;
  assign FC_inputs       = frame_q;
  assign CNN_ready       = cnn_ready_q;
  assign frame_error     = frame_error_q;

endmodule

// File: tb/tb_fc_input_collector.sv
// tb_fc_input_collector: self-checking bench for fc_input_collector.
// A reference model (word index, held flag, expected vector) is advanced by
// the spec's rules on every clock and compared against the DUT outputs.
module tb_fc_input_collector;
  import fc_pkg::*;

  localparam int N = FC_INPUT_SIZE;
  localparam int W = WORD_SIZE;

  logic              clk = 1'b0;
  logic              rst;
  logic              FC_done;
  logic [0:N-1][W-1:0] FC_inputs;
  logic              CNN_ready;
  logic              frame_error;

  fc_input_collector_if #(.DATA_WIDTH(W)) bus ();

  fc_input_collector dut (
    .clk        (clk),
    .rst        (rst),
    .stream     (bus.slave),
    .FC_done    (FC_done),
    .FC_inputs  (FC_inputs),
    .CNN_ready  (CNN_ready),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit                m_hold;
  int                m_cnt;
  bit                m_err;
  bit                m_prev;
  logic [0:N-1][W-1:0] m_vec;

  function automatic logic [W-1:0] ingest(input logic [W-1:0] w);
`ifdef FC_COLLECTOR_RELU_EN
    if (w[W-1]) return '0;
`endif
    return w;
  endfunction

  // Drive one cycle of inputs, advance the model at the clock edge, then
  // settle 1 time unit past the edge so outputs can be sampled.
  task automatic step(input logic v, input logic [W-1:0] d, input logic l,
                      input logic dn, input logic r);
    bit rise;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    FC_done      = dn;
    rst          = r;
    @(posedge clk);
    if (r) begin
      m_hold = 0; m_cnt = 0; m_err = 0; m_prev = 0; m_vec = '0;
    end else begin
      rise  = dn && !m_prev;
      m_err = 0;
      if (m_hold) begin
        if (rise) m_hold = 0;
      end else if (v) begin
        if (m_cnt == N - 1) begin
          m_vec[m_cnt] = ingest(d);
          m_cnt = 0;
          m_hold = 1;
        end else if (l) begin
          m_cnt = 0;
          m_err = 1;
        end else begin
          m_vec[m_cnt] = ingest(d);
          m_cnt++;
        end
      end
      m_prev = dn;
    end
    #1;
  endtask

  // Stream n accepted words with random gaps, done held at the given level.
  task automatic send_words(input int n, input bit last_at_end, input logic dn);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 4 * n + 10) begin
      if ($urandom_range(3) != 0) begin
        step(1, W'($urandom), (last_at_end && sent == n - 1), dn, 0);
        sent++;
      end else begin
        step(0, W'($urandom), 1'($urandom), dn, 0);
      end
      guard++;
    end
  endtask

  task automatic release_hold();
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++;
    if (CNN_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_cnn_ready got %b exp 0", CNN_ready); end
    checks++;
    if (frame_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_error got %b exp 0", frame_error); end
    checks++;
    if (FC_inputs !== '0) begin errors++; $display("[TB] FAIL reset_vector got %h exp 0", FC_inputs[0]); end
  endtask

  task automatic test_full_frame();
    int early = 0;
    for (int i = 1; i <= N; i++) begin
      step(1, W'(i), (i == N), 0, 0);
      if (i < N && CNN_ready !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("[TB] FAIL full_early_ready got %0d cycles exp 0", early); end
    checks++;
    if (CNN_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_cnn_ready got %b exp 1", CNN_ready); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready got %b exp 0", bus.in_ready); end
    checks++;
    if (FC_inputs[0] !== 16'd1) begin errors++; $display("[TB] FAIL full_word0 got %h exp 0001", FC_inputs[0]); end
    checks++;
    if (FC_inputs[N-1] !== 16'd120) begin errors++; $display("[TB] FAIL full_word119 got %h exp 0078", FC_inputs[N-1]); end
    checks++;
    if (FC_inputs !== m_vec) begin
      errors++;
      for (int k = 0; k < N; k++)
        if (FC_inputs[k] !== m_vec[k]) begin
          $display("[TB] FAIL full_vector word %0d got %h exp %h", k, FC_inputs[k], m_vec[k]);
          break;
        end
    end
  endtask

  task automatic test_hold_release();
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 16'hFFFF, 1'($urandom), 0, 0);
      if (CNN_ready !== 1'b1 || bus.in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL hold_handshake got %0d bad cycles exp 0", bad); end
    checks++;
    if (FC_inputs !== m_vec) begin
      errors++;
      for (int k = 0; k < N; k++)
        if (FC_inputs[k] !== m_vec[k]) begin
          $display("[TB] FAIL hold_frozen word %0d got %h exp %h", k, FC_inputs[k], m_vec[k]);
          break;
        end
    end
    step(0, '0, 0, 1, 0);
    checks++;
    if (CNN_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_cnn_ready got %b exp 0", CNN_ready); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready got %b exp 1", bus.in_ready); end
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    checks++;
    if (bus.in_ready !== 1'b1 || CNN_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL release_stays_open got ready %b cnn %b exp 1 0", bus.in_ready, CNN_ready);
    end
    step(0, '0, 0, 0, 0);
  endtask

  task automatic test_stale_done();
    int bad = 0;
    send_words(N, 1, 1);
    checks++;
    if (CNN_ready !== 1'b1) begin errors++; $display("[TB] FAIL stale_enter_hold got %b exp 1", CNN_ready); end
    checks++;
    if (FC_inputs !== m_vec) begin
      errors++;
      for (int k = 0; k < N; k++)
        if (FC_inputs[k] !== m_vec[k]) begin
          $display("[TB] FAIL stale_vector word %0d got %h exp %h", k, FC_inputs[k], m_vec[k]);
          break;
        end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom), W'($urandom), 0, 1, 0);
      if (CNN_ready !== 1'b1) bad++;
    end
    step(0, '0, 0, 0, 0);
    if (CNN_ready !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL stale_stays_hold got %0d bad cycles exp 0", bad); end
    step(0, '0, 0, 1, 0);
    checks++;
    if (CNN_ready !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL stale_release got cnn %b ready %b exp 0 1", CNN_ready, bus.in_ready);
    end
    step(0, '0, 0, 0, 0);
  endtask

  task automatic test_short_frame();
    int pulses = 0;
    int held = 0;
    for (int i = 1; i <= 50; i++) begin
      step(1, W'($urandom), (i == 50), 0, 0);
      if (frame_error === 1'b1) pulses++;
      if (CNN_ready !== 1'b0) held++;
    end
    checks++;
    if (frame_error !== 1'b1) begin errors++; $display("[TB] FAIL short_error_timing got %b exp 1", frame_error); end
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0, 0, 0);
      if (frame_error === 1'b1) pulses++;
      if (CNN_ready !== 1'b0) held++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("[TB] FAIL short_error_pulses got %0d exp 1", pulses); end
    checks++;
    if (held != 0) begin errors++; $display("[TB] FAIL short_cnn_ready got %0d high cycles exp 0", held); end
    send_words(N, 1, 0);
    checks++;
    if (CNN_ready !== 1'b1) begin errors++; $display("[TB] FAIL short_next_frame got %b exp 1", CNN_ready); end
    checks++;
    if (FC_inputs !== m_vec) begin
      errors++;
      for (int k = 0; k < N; k++)
        if (FC_inputs[k] !== m_vec[k]) begin
          $display("[TB] FAIL short_next_vector word %0d got %h exp %h", k, FC_inputs[k], m_vec[k]);
          break;
        end
    end
    release_hold();
  endtask

  task automatic test_reset_mid();
    send_words(60, 0, 0);
    step(1, W'($urandom), 0, 0, 1);
    checks++;
    if (bus.in_ready !== 1'b1 || CNN_ready !== 1'b0 || frame_error !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_outputs got ready %b cnn %b err %b exp 1 0 0", bus.in_ready, CNN_ready, frame_error);
    end
    checks++;
    if (FC_inputs !== '0) begin errors++; $display("[TB] FAIL midreset_vector got word0 %h exp all zero", FC_inputs[0]); end
    send_words(N - 1, 0, 0);
    checks++;
    if (CNN_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_119 got %b exp 0", CNN_ready); end
    step(1, W'($urandom), 0, 0, 0);
    checks++;
    if (CNN_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_120 got %b exp 1", CNN_ready); end
    release_hold();
  endtask

  task automatic test_relu();
    logic [W-1:0] exp0;
`ifdef FC_COLLECTOR_RELU_EN
    exp0 = 16'h0000;
`else
    exp0 = 16'h8001;
`endif
    step(1, 16'h8001, 0, 0, 0);
    step(1, 16'h0005, 0, 0, 0);
    send_words(N - 2, 1, 0);
    checks++;
    if (FC_inputs[0] !== exp0) begin errors++; $display("[TB] FAIL relu_word0 got %h exp %h", FC_inputs[0], exp0); end
    checks++;
    if (FC_inputs[1] !== 16'h0005) begin errors++; $display("[TB] FAIL relu_word1 got %h exp 0005", FC_inputs[1]); end
    checks++;
    if (FC_inputs !== m_vec) begin
      errors++;
      for (int k = 0; k < N; k++)
        if (FC_inputs[k] !== m_vec[k]) begin
          $display("[TB] FAIL relu_vector word %0d got %h exp %h", k, FC_inputs[k], m_vec[k]);
          break;
        end
    end
    release_hold();
  endtask

  task automatic test_random();
    logic dn = 0;
    int bad = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) dn = ~dn;
      step(($urandom_range(3) != 0), W'($urandom), ($urandom_range(199) == 0), dn,
           ($urandom_range(499) == 0));
      checks++;
      if (CNN_ready !== m_hold || bus.in_ready !== !m_hold || frame_error !== m_err || FC_inputs !== m_vec) begin
        errors++;
        if (bad < 5)
          $display("[TB] FAIL random_cycle %0d got cnn %b ready %b err %b exp %b %b %b vec_eq %b",
                   c, CNN_ready, bus.in_ready, frame_error, m_hold, !m_hold, m_err, (FC_inputs === m_vec));
        bad++;
      end
    end
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_data  = '0;
    bus.in_last  = 0;
    FC_done      = 0;
    rst          = 1;
    m_vec        = '0;
    test_reset();
    test_full_frame();
    test_hold_release();
    test_stale_done();
    test_short_frame();
    test_reset_mid();
    test_relu();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_input_collector.md
# fc_input_collector

Upstream feeder for the FC top module. Accepts the CNN's flattened feature words one per cycle over a valid/ready stream, assembles them into the `FC_INPUTS`-word parallel vector, raises `CNN_ready` once a full frame is stored, and holds the vector stable until the FC stage reports `done`. It then re-opens the stream for the next frame. Short frames are detected, flagged and discarded.

## Interface
Parameters:
- `FC_INPUT_SIZE`, 120: words per frame; drives the FC input vector width.
- `WORD_SIZE`, 16: bits per word, signed two's complement fixed point.
- `COUNT_WIDTH`, 7: word-index counter width; must satisfy 2^COUNT_WIDTH >= FC_INPUT_SIZE.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  CNN word present on `in_data`.
- `in_data`  in  WORD_SIZE  CNN feature word.
- `in_last`  in  1  marks the final word of a CNN frame; qualified by `in_valid`.
- `in_ready`  out  1  collector accepts a word this cycle.
- `FC_done`  in  1  the FC top module's `done` output, treated as a level.
- `FC_inputs`  out  [0:FC_INPUT_SIZE-1][WORD_SIZE-1:0]  registered frame vector; word 0 is the first word accepted.
- `CNN_ready`  out  1  frame complete and held; connects to the FC `CNN_ready`.
- `frame_error`  out  1  one-cycle pulse when a short frame is discarded.

## Operation
- State machine with two states, COLLECT and HOLD. Reset puts it in COLLECT.
- COLLECT:
  - `in_ready`=1 and `CNN_ready`=0.
  - A beat is accepted when `in_valid`&`in_ready`. Accepted words are written to `FC_inputs[count]` and `count` is incremented.
- Frame completes on the beat where `count`==FC_INPUT_SIZE-1, whether or not `in_last` is set. On that beat `count` returns to 0 and the state moves to HOLD.
- Short frame: `in_last`=1 on an accepted beat with `count`<FC_INPUT_SIZE-1.
  - The word is not stored, `count` returns to 0 and `frame_error` pulses.
  - The state stays in COLLECT.
  - Words already written remain in `FC_inputs` until overwritten.
- HOLD:
  - `in_ready`=0, `CNN_ready`=1, and `FC_inputs` is frozen.
  - The block leaves HOLD only on a rising edge of `FC_done`, i.e. `FC_done`=1 while the registered copy `done_q`=0. It then returns to COLLECT.
- `done_q` is registered every cycle, in every state.
- A rising edge of `FC_done` during COLLECT is ignored. A `done` level left high from the previous frame therefore never releases a new frame.
- Reset values: state COLLECT, `count`=0, `done_q`=0, all `FC_inputs` words 0, `in_ready`=1, `CNN_ready`=0, `frame_error`=0.
- Reset mid-frame or in HOLD discards everything. `rst` has priority over every other event.

## Timing
- `in_ready` and `CNN_ready` are decoded from the state register only; there is no combinational path from the inputs.
- Latency: the cycle after the final beat is accepted, `CNN_ready`=1 and `in_ready`=0. Full throughput is FC_INPUT_SIZE cycles per frame, plus FC processing time.
- If the rising edge of `FC_done` is sampled at edge t, then from edge t onward `CNN_ready`=0 and `in_ready`=1, and the first word of the next frame can be accepted at edge t+1.
- `frame_error` is high for exactly the cycle after the offending beat.

## Configuration
- Macro `FC_COLLECTOR_RELU_EN`.
- Defined: accepted words with `in_data[WORD_SIZE-1]`=1 are stored as 0. This gives ReLU on ingest. Non-negative words are stored unchanged.
- Undefined: words are stored bit-exact.
- The macro has no effect on handshake or timing.

## Structure
- Shared package `fc_pkg` holds:
  - localparams `FC_INPUT_SIZE`, `WORD_SIZE`, `COUNT_WIDTH`;
  - `typedef logic [WORD_SIZE-1:0] word_t`;
  - `typedef enum logic {COLLECT, HOLD} collector_state_t`.
- One sub-module, `rise_detect`: it registers `FC_done` into `done_q` and outputs `FC_done & ~done_q`. It resets `done_q` to 0.

## Test plan
- **Full frame.** After reset, stream words 1..120 with `in_valid`=1 every cycle and `in_last` on word 120.
  - The cycle after the 120th beat: `CNN_ready`=1, `in_ready`=0.
  - `FC_inputs[0]`=1 and `FC_inputs[119]`=120.
- **Hold and release.** While in HOLD:
  - Drive `in_valid`=1 with 0xFFFF for 10 cycles: `FC_inputs` is unchanged.
  - Pulse `FC_done` high for 3 cycles: `CNN_ready` drops after the first of those cycles, and `in_ready`=1.
- **Stale done.** Keep `FC_done` high through the entire next frame. After 120 beats the block enters HOLD and stays there. Taking `FC_done` low and then high releases it.
- **Short frame.** Send 50 words with `in_last` on word 50.
  - `frame_error` pulses once and `CNN_ready` stays 0.
  - A following 120-word frame completes normally.
- **Reset mid-frame.** Assert `rst` after 60 beats.
  - All outputs return to their reset values and `FC_inputs` is all zeros.
  - A fresh 120 words are then needed for `CNN_ready`.
- **ReLU, with `FC_COLLECTOR_RELU_EN` defined.** In a frame with word 0 = 0x8001 and word 1 = 0x0005: `FC_inputs[0]`=0 and `FC_inputs[1]`=5. Without the macro, `FC_inputs[0]`=0x8001.
